// File: rtl/sram_mem_subsystem.sv
// Multi-cycle SRAM controller plus its two-bank (2 x 32-bit) row array.
// Reads return a full 64-bit row; writes store one 32-bit word.
module sram_mem_subsystem #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          ADDR_W      = 17,
   parameter int          WAIT_CYCLES = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              hit,
   input  logic [31:0]       address,
   input  logic [31:0]       wdata,
   output logic [63:0]       rdata,
   output logic              ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_we_n
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0);
   localparam bit               EARLY_LOAD  = (WAIT_CYCLES == 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  row_q;
   logic               bank_q;
   logic [31:0]        wdata_q;
   logic               wr_q;
   logic               start, capture, done, rd_load;

   logic [ADDR_W+2:0]  eff;
   logic [ADDR_W-1:0]  live_row;
   logic               live_bank;
   logic [ADDR_W-1:0]  rd_row;
   logic               unused_bits;

   logic [31:0] bank0_mem [0:(1<<ADDR_W)-1];
   logic [31:0] bank1_mem [0:(1<<ADDR_W)-1];

   // Only the bits that select a row survive, so the wrap falls out of the narrow subtraction.
   assign eff         = address[ADDR_W+2:0] - BASE_ADDR[ADDR_W+2:0];
   assign live_row    = eff[ADDR_W+2:3];
   assign live_bank   = eff[2];
   assign unused_bits = ^{address[31:ADDR_W+3], eff[1:0]};

   assign start = wr_en | (rd_en & ~hit);

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready   = 1'b0;
      capture = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            ready = ~start;
            if (start) begin
               state_d = BUSY;
               cnt_d   = '0;
               capture = 1'b1;
            end
         end
         BUSY: begin
            if (cnt_q == CNT_LAST) begin
               ready   = 1'b1;
               done    = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The row is loaded one edge before the ready cycle so rdata is valid when ready rises.
   always_comb begin
      if (EARLY_LOAD) begin
         rd_load = capture & ~wr_en;
         rd_row  = live_row;
      end else begin
         rd_load = (state_q == BUSY) && !wr_q && (cnt_q == CNT_PRELAST);
         rd_row  = row_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         row_q     <= '0;
         bank_q    <= 1'b0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         sram_we_n <= 1'b1;
         rdata     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            row_q     <= live_row;
            bank_q    <= live_bank;
            wdata_q   <= wdata;
            wr_q      <= wr_en;
            sram_we_n <= ~wr_en;
         end
         if (done)
            sram_we_n <= 1'b1;
         if (rd_load)
            rdata <= {bank1_mem[rd_row], bank0_mem[rd_row]};
      end
   end

   // NOTE: the array has no reset; an aborted write is blocked because reset forces state_q to IDLE.
   always_ff @(posedge clk) begin
      if (done && wr_q) begin
         if (bank_q)
            bank1_mem[row_q] <= wdata_q;
         else
            bank0_mem[row_q] <= wdata_q;
      end
   end

   assign sram_addr = (!rst) ? '0 : (state_q == BUSY) ? row_q : live_row;

endmodule

// File: tb/tb_sram_mem_subsystem.sv
// Directed bench for sram_mem_subsystem: table of whole accesses plus hand-written
// sequences for reset abort, cache hit and back-to-back held reads.
module tb_sram_mem_subsystem;

   localparam int WAIT = 5;
   localparam int NV   = 18;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en, hit;
   logic [31:0] address, wdata;
   logic [63:0] rdata;
   logic        ready;
   logic [16:0] sram_addr;
   logic        sram_we_n;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic        wr;
      logic        rd;
      logic        drop;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [NV];

   sram_mem_subsystem dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .hit       (hit),
      .address   (address),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .sram_addr (sram_addr),
      .sram_we_n (sram_we_n)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [16:0] exp_row(input logic [31:0] a);
      logic [31:0] e;
      e = a - 32'd1024;
      return e[19:3];
   endfunction

   function automatic vec_t mk(input logic wr, input logic rd, input logic drop,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic chk, input logic [63:0] exp);
      vec_t v;
      v.wr = wr; v.rd = rd; v.drop = drop; v.addr = a; v.wdata = d; v.chk = chk; v.exp = exp;
      return v;
   endfunction

   task automatic run_vec(input int i);
      vec_t v;
      v = vecs[i];
      @(posedge clk); #1;
      wr_en = v.wr; rd_en = v.rd; hit = 1'b0; address = v.addr; wdata = v.wdata;
      for (int c = 0; c <= WAIT; c++) begin
         @(negedge clk);
         check($sformatf("v%0d ready c%0d", i, c), {63'd0, ready}, {63'd0, c == WAIT});
         check($sformatf("v%0d we_n c%0d", i, c), {63'd0, sram_we_n},
               {63'd0, (c == 0) ? 1'b1 : ~v.wr});
         check($sformatf("v%0d sram_addr c%0d", i, c), {47'd0, sram_addr}, {47'd0, exp_row(v.addr)});
         if (c == WAIT && v.chk)
            check($sformatf("v%0d rdata", i), rdata, v.exp);
         if (c == 1 && v.drop) begin
            wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_0000; wdata = 32'h0;
         end
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      vecs[0]  = mk(1, 0, 0, 32'd1048, 32'h0F0F0F0F, 0, 64'h0);
      vecs[1]  = mk(1, 0, 0, 32'd1052, 32'h13579BDF, 0, 64'h0);
      vecs[2]  = mk(0, 1, 0, 32'd1048, 32'h0,        1, 64'h13579BDF_0F0F0F0F);
      vecs[3]  = mk(0, 1, 0, 32'd1048, 32'h0,        1, 64'h13579BDF_0F0F0F0F);
      vecs[4]  = mk(1, 0, 0, 32'd1024, 32'hDEADBEEF, 0, 64'h0);
      vecs[5]  = mk(1, 0, 0, 32'd1028, 32'h12345678, 0, 64'h0);
      vecs[6]  = mk(0, 1, 0, 32'd1024, 32'h0,        1, 64'h12345678_DEADBEEF);
      vecs[7]  = mk(1, 0, 0, 32'd1036, 32'h11112222, 0, 64'h0);
      vecs[8]  = mk(1, 1, 1, 32'd1032, 32'hA5A5A5A5, 1, 64'h12345678_DEADBEEF);
      vecs[9]  = mk(0, 1, 0, 32'd1032, 32'h0,        1, 64'h11112222_A5A5A5A5);
      vecs[10] = mk(1, 0, 0, 32'd1040, 32'h0BADF00D, 0, 64'h0);
      vecs[11] = mk(1, 0, 1, 32'd1044, 32'h600DCAFE, 0, 64'h0);
      vecs[12] = mk(0, 1, 0, 32'd1024 + (32'd1 << 20), 32'h0, 1, 64'h12345678_DEADBEEF);
      vecs[13] = mk(1, 0, 0, 32'd1036 + (32'd1 << 20), 32'h77778888, 0, 64'h0);
      vecs[14] = mk(0, 1, 0, 32'd1032, 32'h0,        1, 64'h77778888_A5A5A5A5);
      vecs[15] = mk(1, 0, 0, 32'd1016, 32'h33CC33CC, 0, 64'h0);
      vecs[16] = mk(1, 0, 0, 32'd1020, 32'h55AA55AA, 0, 64'h0);
      vecs[17] = mk(0, 1, 0, 32'd1016 + (32'd1 << 20), 32'h0, 1, 64'h55AA55AA_33CC33CC);

      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; hit = 1'b0; address = 32'd1024; wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("reset ready", {63'd0, ready}, 64'd1);
      check("reset rdata", rdata, 64'h0);
      check("reset we_n", {63'd0, sram_we_n}, 64'd1);
      check("reset sram_addr", {47'd0, sram_addr}, 64'd0);
      rst = 1'b1;

      for (int i = 0; i <= 2; i++) run_vec(i);

      // Write aborted by reset in the middle of BUSY.
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1048; wdata = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      rst = 1'b0; wr_en = 1'b0;
      #1;
      check("abort ready", {63'd0, ready}, 64'd1);
      check("abort rdata", rdata, 64'h0);
      check("abort we_n", {63'd0, sram_we_n}, 64'd1);
      check("abort sram_addr", {47'd0, sram_addr}, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 3; i <= 6; i++) run_vec(i);

      // Cache hit: no access, ready stays high, rdata untouched.
      @(posedge clk); #1;
      rd_en = 1'b1; hit = 1'b1; address = 32'd1040;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("hit ready c%0d", c), {63'd0, ready}, 64'd1);
         check($sformatf("hit we_n c%0d", c), {63'd0, sram_we_n}, 64'd1);
         check($sformatf("hit rdata c%0d", c), rdata, 64'h12345678_DEADBEEF);
      end
      rd_en = 1'b0; hit = 1'b0;

      for (int i = 7; i <= 11; i++) run_vec(i);

      // Back-to-back reads with rd_en held; address advances on the ready cycle.
      @(posedge clk); #1;
      rd_en = 1'b1; address = 32'd1024;
      for (int c = 0; c <= 2 * WAIT + 1; c++) begin
         @(negedge clk);
         check($sformatf("b2b ready c%0d", c), {63'd0, ready},
               {63'd0, (c == WAIT) || (c == 2 * WAIT + 1)});
         check($sformatf("b2b sram_addr c%0d", c), {47'd0, sram_addr},
               {47'd0, (c <= WAIT) ? 17'd0 : 17'd2});
         if (c == WAIT) begin
            check("b2b rdata row0", rdata, 64'h12345678_DEADBEEF);
            address = 32'd1040;
         end
         if (c == 2 * WAIT + 1) begin
            check("b2b rdata row2", rdata, 64'h600DCAFE_0BADF00D);
            rd_en = 1'b0;
         end
      end

      for (int i = 12; i < NV; i++) run_vec(i);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
